serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that drives one fullAdder cell: one operand bit pair per clock, LSB first.
- Registers the carry between cycles and assembles the sum.
- Sits directly upstream and downstream of the fullAdder cell. It feeds X, Y and Cin, and consumes A and Cout.
- Trades area for latency in the arithmetic datapath: one adder cell instead of WIDTH cells.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2 to 32.
- CNT_W, $clog2(WIDTH), bit-count register width (localparam, not overridable).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered final carry-out; holds its value until the next completion.

Behaviour:
- Reset (rst_n low): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry flop and counter = 0.
- States and transitions:
  - IDLE: on a clk edge with start=1, load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge performs the following.
    - acc_sh <= {fa_A, acc_sh[WIDTH-1:1]}; a_sh>>=1; b_sh>>=1; carry<=fa_Cout; cnt<=cnt+1.
    - When cnt==WIDTH-1 on that edge: sum<={fa_A, acc_sh[WIDTH-1:1]}, cout<=fa_Cout, go to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE.
- fullAdder hookup (combinational): X=a_sh[0], Y=b_sh[0], Cin=carry.
- Timing: start accepted at edge 0; SHIFT spans edges 1..WIDTH; done is high in the cycle after edge WIDTH.
  - Latency from accepting edge to done = WIDTH+1 cycles.
  - Minimum start-to-start spacing = WIDTH+2 cycles.
- busy and done are decoded from registered state only; no combinational path from start.
- start while busy (SHIFT or DONE): ignored; no queuing. start held high continuously re-triggers on the first IDLE cycle.
- a, b, cin changing after the accepting edge: no effect on the in-flight result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned. Overflow appears only in cout.
- Counter: cnt never wraps; it is reloaded to 0 on each accept.
- Reset mid-operation: abort immediately; no done pulse; sum and cout forced to 0.
- sum and cout do not change during SHIFT; the previous result stays visible until the completion edge.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- 2'd3 is unreachable and is treated as IDLE (default branch).
- One sub-module instance: fullAdder (existing cell), instance name u_fa.
- Shift and count logic stays inline.

Test Plan (WIDTH=8):
- a=0x5A, b=0x3C, cin=0, start pulse -> done exactly 9 cycles after the accepting edge; sum=0x96, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Carry ripples across all 8 serial steps.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0 (carry flop correctly reloaded).
- start held high; a, b randomised every cycle after accept -> results every 10 cycles, each matching the operands captured on its own accepting edge; no extra done pulses.
- Accept a=0x12, b=0x34, then drop rst_n at cycle 4 of SHIFT -> busy=0, done never pulses, sum=0, cout=0. After release, a=0x01, b=0x02 -> sum=0x03, cout=0.
- Random regression, 1000 operations, WIDTH=8 and WIDTH=16 -> {cout,sum} equals a+b+cin for every done pulse.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Provides the state encoding and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell used by the serial adder.
// Purely combinational.
module fullAdder (
  input  logic X,
  input  logic Y,
  input  logic Cin,
  output logic A,
  output logic Cout
);

  assign A    = X ^ Y ^ Cin;
  assign Cout = (X & Y) | (X & Cin) | (Y & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder cell, one operand bit pair per
// clock, LSB first; carry is held in a flop between steps.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_a;
  logic               fa_cout;
  logic [WIDTH-1:0]   acc_nxt;
  logic               last;

  fullAdder u_fa (
    .X    (a_sh[0]),
    .Y    (b_sh[0]),
    .Cin  (carry),
    .A    (fa_a),
    .Cout (fa_cout)
  );

  assign acc_nxt = {fa_a, acc_sh[WIDTH-1:1]};
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_SHIFT: begin
          acc_sh <= acc_nxt;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          if (last) begin
            sum   <= acc_nxt;
            cout  <= fa_cout;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        // 2'd3 cannot be reached; it behaves exactly like IDLE
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
